dma_rd_wr_ctlr: RTL and testbench

DMA read/write controller on the MAC platform side. It executes one word-burst command at a time on behalf of whichever client the DMA arbiter has granted (receive list processor, transmit status updater or transmit list processor), and drives single-beat transfers on the platform bus. It reports `rdWrCtlrIdle` back to the arbiter so that the arbiter only issues a new grant between commands. Client command and data signals arrive already multiplexed by the grant.

---
 rtl/dma_rd_wr_ctlr_pkg.sv | 32 +++
 rtl/dma_rd_wr_ctlr.sv | 157 +++++++++++++++
 tb/tb_dma_rd_wr_ctlr.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/dma_rd_wr_ctlr_pkg.sv
// rtl/dma_rd_wr_ctlr_pkg.sv - shared MAC DMA state encoding and beat helpers
package dma_rd_wr_ctlr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_DATA = 3'd1,
    ST_WR_BEAT = 3'd2,
    ST_RD_BEAT = 3'd3,
    ST_DONE    = 3'd4
  } dma_state_e;

  localparam int BEAT_INC = 4;

  // A zero length field encodes the maximum burst of 256 beats.
  function automatic logic [8:0] len_to_beats(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

`ifndef SYNTHESIS
  function automatic string state_name(input dma_state_e s);
    case (s)
      ST_IDLE:    return "IDLE";
      ST_WR_DATA: return "WR_DATA";
      ST_WR_BEAT: return "WR_BEAT";
      ST_RD_BEAT: return "RD_BEAT";
      ST_DONE:    return "DONE";
      default:    return "ILLEGAL";
    endcase
  endfunction
`endif

endpackage

// File: rtl/dma_rd_wr_ctlr.sv
// rtl/dma_rd_wr_ctlr.sv - single-command word-burst DMA read/write controller
module dma_rd_wr_ctlr
  import dma_rd_wr_ctlr_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              macPIClk,
  input  logic              macPIClkHardRst_n,
  input  logic              macPIClkSoftRst_n,
  output logic              rdWrCtlrIdle,
  input  logic              cmdValid,
  output logic              cmdReady,
  input  logic              cmdWrite,
  input  logic [ADDR_W-1:0] cmdAddr,
  input  logic [7:0]        cmdLen,
  output logic              cmdDone,
  output logic              cmdErr,
  input  logic              wrDataValid,
  output logic              wrDataReady,
  input  logic [DATA_W-1:0] wrData,
  output logic              rdDataValid,
  output logic [DATA_W-1:0] rdData,
  output logic              busTrans,
  output logic              busWrite,
  output logic [ADDR_W-1:0] busAddr,
  output logic [DATA_W-1:0] busWData,
  input  logic              busReady,
  input  logic              busErr,
  input  logic [DATA_W-1:0] busRData
);

  dma_state_e        state_d, state_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [8:0]        cnt_d, cnt_q;
  logic [DATA_W-1:0] wdata_d, wdata_q, rdata_d, rdata_q;
  logic              err_d, err_q, rd_valid_d, rd_valid_q, done_d, done_q;
  logic              idle_d, idle_q, trans_d, trans_q, bwrite_d, bwrite_q;
  logic              wr_ready_d, wr_ready_q;
  logic              last_beat;

  assign last_beat = (cnt_q == 9'd1);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    rd_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmdValid) begin
          addr_d  = cmdAddr & ~ADDR_W'(BEAT_INC - 1);
          cnt_d   = len_to_beats(cmdLen);
          err_d   = 1'b0;
          state_d = cmdWrite ? ST_WR_DATA : ST_RD_BEAT;
        end
      end
      ST_WR_DATA: begin
        if (wrDataValid) begin
          wdata_d = wrData;
          state_d = ST_WR_BEAT;
        end
      end
      ST_WR_BEAT: begin
        if (busReady && busErr) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (busReady) begin
          addr_d  = addr_q + ADDR_W'(BEAT_INC);
          cnt_d   = cnt_q - 9'd1;
          state_d = last_beat ? ST_DONE : ST_WR_DATA;
        end
      end
      ST_RD_BEAT: begin
        if (busReady && busErr) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (busReady) begin
          rdata_d    = busRData;
          rd_valid_d = 1'b1;
          addr_d     = addr_q + ADDR_W'(BEAT_INC);
          cnt_d      = cnt_q - 9'd1;
          state_d    = last_beat ? ST_DONE : ST_RD_BEAT;
        end
      end
      ST_DONE: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Soft reset abandons any in-flight beat and returns every output to its reset value.
    if (!macPIClkSoftRst_n) begin
      state_d    = ST_IDLE;
      addr_d     = '0;
      cnt_d      = '0;
      wdata_d    = '0;
      rdata_d    = '0;
      err_d      = 1'b0;
      rd_valid_d = 1'b0;
    end

    // Outputs are decoded from the next state so they leave the flops glitch-free.
    idle_d     = (state_d == ST_IDLE);
    trans_d    = (state_d == ST_WR_BEAT) || (state_d == ST_RD_BEAT);
    bwrite_d   = (state_d == ST_WR_BEAT);
    wr_ready_d = (state_d == ST_WR_DATA);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge macPIClk or negedge macPIClkHardRst_n) begin
    if (!macPIClkHardRst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      idle_q     <= 1'b1;
      trans_q    <= 1'b0;
      bwrite_q   <= 1'b0;
      wr_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      idle_q     <= idle_d;
      trans_q    <= trans_d;
      bwrite_q   <= bwrite_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  assign rdWrCtlrIdle = idle_q;
  assign cmdReady     = idle_q;
  assign cmdDone      = done_q;
  assign cmdErr       = err_q;
  assign wrDataReady  = wr_ready_q;
  assign rdDataValid  = rd_valid_q;
  assign rdData       = rdata_q;
  assign busTrans     = trans_q;
  assign busWrite     = bwrite_q;
  assign busAddr      = addr_q;
  assign busWData     = wdata_q;

endmodule

// File: tb/tb_dma_rd_wr_ctlr.sv
// tb/tb_dma_rd_wr_ctlr.sv - directed table-driven bench for dma_rd_wr_ctlr
module tb_dma_rd_wr_ctlr;

  logic        clk = 1'b0;
  logic        hard_rst_n = 1'b0;
  logic        soft_rst_n = 1'b1;
  logic        rdWrCtlrIdle, cmdReady, cmdDone, cmdErr;
  logic        cmdValid = 1'b0, cmdWrite = 1'b0;
  logic [31:0] cmdAddr = '0;
  logic [7:0]  cmdLen = '0;
  logic        wrDataValid = 1'b0, wrDataReady;
  logic [31:0] wrData = '0;
  logic        rdDataValid;
  logic [31:0] rdData;
  logic        busTrans, busWrite;
  logic [31:0] busAddr, busWData;
  logic        busReady = 1'b0, busErr = 1'b0;
  logic [31:0] busRData = '0;

  int checks = 0;
  int errors = 0;

  dma_rd_wr_ctlr #(.ADDR_W(32), .DATA_W(32)) dut (
    .macPIClk(clk), .macPIClkHardRst_n(hard_rst_n), .macPIClkSoftRst_n(soft_rst_n),
    .rdWrCtlrIdle(rdWrCtlrIdle), .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdWrite(cmdWrite), .cmdAddr(cmdAddr), .cmdLen(cmdLen), .cmdDone(cmdDone),
    .cmdErr(cmdErr), .wrDataValid(wrDataValid), .wrDataReady(wrDataReady),
    .wrData(wrData), .rdDataValid(rdDataValid), .rdData(rdData),
    .busTrans(busTrans), .busWrite(busWrite), .busAddr(busAddr), .busWData(busWData),
    .busReady(busReady), .busErr(busErr), .busRData(busRData)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  len;
    int          wait_n;
    int          wr_dly;
    int          err_beat;
    int          srst_beat;
    bit          hold;
    logic [31:0] exp_addr0;
    int          exp_beats;
    int          exp_rd;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drain();
    int n = 0;
    bit seen = 0;
    while (!seen && n < 2000) begin
      @(posedge clk); #1;
      busReady    = busTrans;
      busErr      = 1'b0;
      wrDataValid = wrDataReady;
      @(negedge clk);
      if (cmdDone) seen = 1;
      n++;
    end
    chk("drain_done", 32'(seen), 32'd1);
    busReady = 1'b0;
    wrDataValid = 1'b0;
  endtask

  task automatic run_cmd(input vec_t v);
    int beats = 0, rd = 0, trans = 0, waitc = 0, wdc = 0, cyc = 1;
    int last_rdy = -10, first_trans = -1;
    bit in_wait = 0, done = 0, aborted = 0;
    logic [31:0] held_addr = '0, held_wdata = '0;
    @(posedge clk); #1;
    chk({v.name, "_pre_idle"}, 32'(rdWrCtlrIdle), 32'd1);
    cmdValid = 1'b1; cmdWrite = v.wr; cmdAddr = v.addr; cmdLen = v.len;
    @(posedge clk); #1;
    if (!v.hold) cmdValid = 1'b0;
    while (!done && !aborted && cyc < 3000) begin
      busReady    = busTrans && (waitc == v.wait_n);
      busErr      = busReady && (beats == v.err_beat);
      busRData    = 32'h5A00_0000 + 32'(beats);
      wrDataValid = wrDataReady && (wdc >= v.wr_dly);
      wrData      = 32'hA500_0000 + 32'(beats);
      if (v.srst_beat >= 0 && busTrans && beats == v.srst_beat) begin
        soft_rst_n = 1'b0; busReady = 1'b0; busErr = 1'b0;
      end
      @(negedge clk);
      chk({v.name, "_busy"}, 32'({rdWrCtlrIdle, cmdReady}), 32'd0);
      if (rdDataValid) begin
        chk({v.name, "_rd_lat"}, 32'(cyc), 32'(last_rdy + 1));
        chk({v.name, "_rd_data"}, rdData, 32'h5A00_0000 + 32'(beats - 1));
        rd++;
      end
      if (cmdDone) begin
        chk({v.name, "_done_lat"}, 32'(cyc), 32'(last_rdy + 1));
        chk({v.name, "_err"}, 32'(cmdErr), 32'(v.exp_err));
        chk({v.name, "_beats"}, 32'(beats), 32'(v.exp_beats));
        chk({v.name, "_rd_cnt"}, 32'(rd), 32'(v.exp_rd));
        chk({v.name, "_trans_cyc"}, 32'(trans), 32'(v.exp_beats * (v.wait_n + 1)));
        done = 1;
      end
      if (busTrans) begin
        if (first_trans < 0) first_trans = cyc;
        trans++;
        if (in_wait) begin
          chk({v.name, "_hold_addr"}, busAddr, held_addr);
          if (v.wr) chk({v.name, "_hold_wdata"}, busWData, held_wdata);
        end
        chk({v.name, "_addr"}, busAddr, v.exp_addr0 + 32'(4 * beats));
        chk({v.name, "_dir"}, 32'(busWrite), 32'(v.wr));
        if (v.wr) chk({v.name, "_wdata"}, busWData, 32'hA500_0000 + 32'(beats));
        held_addr = busAddr; held_wdata = busWData;
        if (busReady) begin
          last_rdy = cyc; beats++; waitc = 0; in_wait = 0;
        end else begin
          waitc++; in_wait = 1;
        end
      end
      if (wrDataReady && !wrDataValid) wdc++;
      else wdc = 0;
      if (!soft_rst_n) begin
        @(posedge clk); #1;
        busReady = 1'b0; wrDataValid = 1'b0;
        @(negedge clk);
        chk({v.name, "_srst_idle"}, 32'({rdWrCtlrIdle, cmdReady}), 32'd3);
        chk({v.name, "_srst_trans"}, 32'(busTrans), 32'd0);
        chk({v.name, "_srst_wrrdy"}, 32'(wrDataReady), 32'd0);
        chk({v.name, "_srst_done"}, 32'(cmdDone), 32'd0);
        soft_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk({v.name, "_srst_no_done"}, 32'({cmdDone, busTrans}), 32'd0);
        end
        aborted = 1;
      end
      if (!done && !aborted) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    busReady = 1'b0; busErr = 1'b0; wrDataValid = 1'b0;
    if (aborted) return;
    chk({v.name, "_timeout"}, 32'(done), 32'd1);
    if (!v.wr) chk({v.name, "_first_trans"}, 32'(first_trans), 32'd1);
    @(negedge clk);
    chk({v.name, "_idle_back"}, 32'({rdWrCtlrIdle, cmdReady, cmdDone}), 32'b110);
    if (v.hold) begin
      @(posedge clk); #1;
      cmdValid = 1'b0;
      @(negedge clk);
      chk({v.name, "_reaccept"}, 32'(rdWrCtlrIdle), 32'd0);
      chk({v.name, "_reaccept_trans"}, 32'(busTrans), 32'(!v.wr));
      chk({v.name, "_reaccept_addr"}, busAddr, v.exp_addr0);
      drain();
    end
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"rd3",   1'b0, 32'h0000_1000, 8'd3, 0, 0, -1, -1, 1'b0, 32'h0000_1000,   3,   3, 1'b0});
    vecs.push_back('{"wr2",   1'b1, 32'h0000_2002, 8'd2, 3, 2, -1, -1, 1'b0, 32'h0000_2000,   2,   0, 1'b0});
    vecs.push_back('{"rderr", 1'b0, 32'h0000_3000, 8'd4, 0, 0,  1, -1, 1'b0, 32'h0000_3000,   2,   1, 1'b1});
    vecs.push_back('{"rd256", 1'b0, 32'hFFFF_FFF8, 8'd0, 0, 0, -1, -1, 1'b0, 32'hFFFF_FFF8, 256, 256, 1'b0});
    vecs.push_back('{"wrerr", 1'b1, 32'h0000_0403, 8'd1, 0, 0,  0, -1, 1'b0, 32'h0000_0400,   1,   0, 1'b1});
    vecs.push_back('{"rdw1",  1'b0, 32'h0000_0010, 8'd2, 1, 0, -1, -1, 1'b0, 32'h0000_0010,   2,   2, 1'b0});
    vecs.push_back('{"srst",  1'b1, 32'h0000_5000, 8'd5, 0, 1, -1,  1, 1'b0, 32'h0000_5000,   0,   0, 1'b0});
    vecs.push_back('{"rdnew", 1'b0, 32'h0000_7004, 8'd1, 0, 0, -1, -1, 1'b0, 32'h0000_7004,   1,   1, 1'b0});
    vecs.push_back('{"hold",  1'b0, 32'h0000_6000, 8'd2, 0, 0, -1, -1, 1'b1, 32'h0000_6000,   2,   2, 1'b0});

    repeat (3) @(negedge clk);
    chk("rst_idle", 32'({rdWrCtlrIdle, cmdReady}), 32'd3);
    chk("rst_ctrl", 32'({cmdDone, cmdErr, wrDataReady, rdDataValid, busTrans, busWrite}), 32'd0);
    chk("rst_addr", busAddr, 32'd0);
    chk("rst_wdata", busWData, 32'd0);
    chk("rst_rdata", rdData, 32'd0);
    hard_rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 32'({rdWrCtlrIdle, cmdReady, busTrans}), 32'b110);

    foreach (vecs[i]) run_cmd(vecs[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
